dm_abstract_ctl: RTL and testbench

DM_ABSTRACT_CTL -- requirements
Module: dm_abstract_ctl

---
 rtl/dm_abstract_ctl_if.sv | 40 ++++
 rtl/dm_abstract_ctl.sv | 152 +++++++++++++++
 tb/tb_dm_abstract_ctl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_abstract_ctl_if.sv
// dm_abstract_ctl_if -- debug-module abstract-command bus.
// Bundles the DM register-side strobes, the hart debug status inputs and
// the hart control/abstractcs outputs of dm_abstract_ctl.
//   master : debugger/DM register side (drives requests and hart status)
//   slave  : dm_abstract_ctl
interface dm_abstract_ctl_if;
  logic        dmactive;
  logic        haltreq;
  logic        resumereq_wr;
  logic        command_wr;
  logic [31:0] command_data;
  logic        cmderr_wr;
  logic [2:0]  cmderr_w1c;
  logic        hart_halted;
  logic        hart_done;
  logic        hart_exception;
  logic        hart_bus;
  logic        hart_haltresume;
  logic        halt_req;
  logic        resume_req;
  logic        exec;
  logic [31:0] command;
  logic        busy;
  logic [2:0]  cmderr;
  logic        resumeack;

  modport master (
    output dmactive, haltreq, resumereq_wr, command_wr, command_data,
           cmderr_wr, cmderr_w1c, hart_halted, hart_done, hart_exception,
           hart_bus, hart_haltresume,
    input  halt_req, resume_req, exec, command, busy, cmderr, resumeack
  );

  modport slave (
    input  dmactive, haltreq, resumereq_wr, command_wr, command_data,
           cmderr_wr, cmderr_w1c, hart_halted, hart_done, hart_exception,
           hart_bus, hart_haltresume,
    output halt_req, resume_req, exec, command, busy, cmderr, resumeack
  );
endinterface

// File: rtl/dm_abstract_ctl.sv
// dm_abstract_ctl -- RISC-V debug module abstract command / resume control.
// Latches abstract commands, runs them on the hart (IDLE/EXEC/RESUME FSM),
// tracks sticky abstractcs.cmderr and dmstatus.allresumeack.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   dm    : dm_abstract_ctl_if.slave (request strobes, hart status in;
//           halt_req/resume_req/exec/command/busy/cmderr/resumeack out)
// Optional feature: define DM_ABSTRACT_TIMEOUT_EN to abort an EXEC that
// sees no hart_done with cmderr=7 (exec held for 255 cycles).
module dm_abstract_ctl (
  input  logic              clk,
  input  logic              rst_n,
  dm_abstract_ctl_if.slave  dm
);

  typedef enum logic [1:0] {IDLE, EXEC, RESUME} state_e;

  state_e      state_q, state_d;
  logic [31:0] command_q, command_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        resumeack_q, resumeack_d;
  logic [7:0]  cmdtype;
  logic        err_set;
  logic [2:0]  err_code;
`ifdef DM_ABSTRACT_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      command_q   <= '0;
      cmderr_q    <= '0;
      resumeack_q <= 1'b0;
`ifdef DM_ABSTRACT_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      command_q   <= command_d;
      cmderr_q    <= cmderr_d;
      resumeack_q <= resumeack_d;
`ifdef DM_ABSTRACT_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    command_d   = command_q;
    resumeack_d = resumeack_q;
    err_set     = 1'b0;
    err_code    = '0;
    cmdtype     = dm.command_data[31:24];
`ifdef DM_ABSTRACT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dm.command_wr && cmderr_q == '0) begin
          command_d = dm.command_data;
          if ((cmdtype == 8'd0 || cmdtype == 8'd2) && !dm.hart_halted) begin
            err_set  = 1'b1;
            err_code = 3'd4;
          end else if (cmdtype > 8'd2) begin
            err_set  = 1'b1;
            err_code = 3'd2;
          end else begin
            state_d = EXEC;
`ifdef DM_ABSTRACT_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else if (dm.resumereq_wr && dm.hart_halted && !dm.haltreq) begin
          resumeack_d = 1'b0;
          state_d     = RESUME;
        end
      end
      EXEC: begin
        // A write while busy is reported ahead of the hart's completion status.
        if (dm.command_wr) begin
          err_set  = 1'b1;
          err_code = 3'd1;
        end
`ifdef DM_ABSTRACT_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (dm.hart_done) begin
          state_d = IDLE;
          if (!err_set) begin
            if (dm.hart_exception) begin
              err_set = 1'b1; err_code = 3'd3;
            end else if (dm.hart_bus) begin
              err_set = 1'b1; err_code = 3'd5;
            end else if (dm.hart_haltresume) begin
              err_set = 1'b1; err_code = 3'd4;
            end
          end
        end
`ifdef DM_ABSTRACT_TIMEOUT_EN
        else if (cnt_d == 8'hFF) begin
          state_d = IDLE;
          if (!err_set) begin
            err_set = 1'b1; err_code = 3'd7;
          end
        end
`endif
      end
      RESUME: begin
        if (dm.command_wr) begin
          err_set  = 1'b1;
          err_code = 3'd1;
        end
        if (!dm.hart_halted) begin
          resumeack_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear first, then a new error (only possible when cmderr is 0) overrides.
    cmderr_d = cmderr_q;
    if (dm.cmderr_wr && state_q != EXEC)
      cmderr_d = cmderr_q & ~dm.cmderr_w1c;
    if (err_set && cmderr_q == '0)
      cmderr_d = err_code;

    if (!dm.dmactive) begin
      state_d     = IDLE;
      command_d   = '0;
      cmderr_d    = '0;
      resumeack_d = 1'b0;
`ifdef DM_ABSTRACT_TIMEOUT_EN
      cnt_d       = '0;
`endif
    end
  end

  always_comb begin
    dm.exec       = (state_q == EXEC);
    dm.busy       = (state_q == EXEC);
    dm.resume_req = (state_q == RESUME);
    dm.halt_req   = dm.haltreq && dm.dmactive;
    dm.command    = command_q;
    dm.cmderr     = cmderr_q;
    dm.resumeack  = resumeack_q;
  end

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// tb_dm_abstract_ctl -- self-checking bench for dm_abstract_ctl.
// Per-cycle vector table with a scoreboard queue, plus hand sequences for
// the EXEC timeout / indefinite wait and asynchronous reset during EXEC.
module tb_dm_abstract_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_abstract_ctl_if dm ();

  dm_abstract_ctl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dm    (dm.slave)
  );

  typedef struct {
    string       name;
    logic        dma, hreq, rwr, cwr;
    logic [31:0] cdata;
    logic        cerw;
    logic [2:0]  w1c;
    logic        halted, done, exc, bus, hr;
    logic [39:0] exp;   // {exec,resume_req,busy,halt_req,cmderr,resumeack,command}
  } vec_t;

  typedef struct {
    string       name;
    logic [39:0] exp;
  } sb_t;

  localparam logic [31:0] D  = 32'h0022_1001;
  localparam logic [31:0] R  = 32'h0022_1002;
  localparam logic [31:0] Q  = 32'h0100_0000;
  localparam logic [31:0] B3 = 32'h0300_0000;
  localparam logic [31:0] B5 = 32'h0500_0000;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input string n, input logic dma, input logic hreq, input logic rwr,
    input logic cwr, input logic [31:0] cd, input logic cerw, input logic [2:0] w1c,
    input logic halted, input logic done, input logic exc, input logic bus,
    input logic hr, input logic ex, input logic rs, input logic bz, input logic hq,
    input logic [2:0] ce, input logic ak, input logic [31:0] cm);
    vec_t v;
    v.name = n; v.dma = dma; v.hreq = hreq; v.rwr = rwr; v.cwr = cwr;
    v.cdata = cd; v.cerw = cerw; v.w1c = w1c; v.halted = halted;
    v.done = done; v.exc = exc; v.bus = bus; v.hr = hr;
    v.exp = {ex, rs, bz, hq, ce, ak, cm};
    return v;
  endfunction

  function automatic logic [39:0] outs();
    return {dm.exec, dm.resume_req, dm.busy, dm.halt_req, dm.cmderr,
            dm.resumeack, dm.command};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dm.dmactive        = v.dma;
    dm.haltreq         = v.hreq;
    dm.resumereq_wr    = v.rwr;
    dm.command_wr      = v.cwr;
    dm.command_data    = v.cdata;
    dm.cmderr_wr       = v.cerw;
    dm.cmderr_w1c      = v.w1c;
    dm.hart_halted     = v.halted;
    dm.hart_done       = v.done;
    dm.hart_exception  = v.exc;
    dm.hart_bus        = v.bus;
    dm.hart_haltresume = v.hr;
  endtask

  task automatic step(input vec_t v);
    sb_t s;
    @(negedge clk);
    drive(v);
    s.name = v.name;
    s.exp  = v.exp;
    sbq.push_back(s);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      s = sbq.pop_front();
      check(s.name, outs(), s.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    //         name            dma hq rw cw data cer w1c   hal dn ex bs hr | ex rs bz hq err ak cmd
    vecs.push_back(mk("idle",          1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    vecs.push_back(mk("cmd_go",        1,0,0,1,D, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("exec_w1",       1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("exec_w2",       1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("exec_done",     1,0,0,0,'0,0,3'b000, 1,1,0,0,0, 0,0,0,0,3'd0,0,D));
    vecs.push_back(mk("cmd_running",   1,0,0,1,R, 0,3'b000, 0,0,0,0,0, 0,0,0,0,3'd4,0,R));
    vecs.push_back(mk("cmd_when_err",  1,0,0,1,Q, 0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd4,0,R));
    vecs.push_back(mk("clear_all",     1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,R));
    vecs.push_back(mk("bad_type",      1,0,0,1,B3,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd2,0,B3));
    vecs.push_back(mk("clear_bit0",    1,0,0,0,'0,1,3'b001, 1,0,0,0,0, 0,0,0,0,3'd2,0,B3));
    vecs.push_back(mk("clear_bit1",    1,0,0,0,'0,1,3'b010, 1,0,0,0,0, 0,0,0,0,3'd0,0,B3));
    vecs.push_back(mk("qa_go",         1,0,0,1,Q, 0,3'b000, 0,0,0,0,0, 1,0,1,0,3'd0,0,Q));
    vecs.push_back(mk("busy_wr",       1,0,0,1,D, 0,3'b000, 0,0,0,0,0, 1,0,1,0,3'd1,0,Q));
    vecs.push_back(mk("clear_busy",    1,0,0,0,'0,1,3'b111, 0,0,0,0,0, 1,0,1,0,3'd1,0,Q));
    vecs.push_back(mk("done_exc",      1,0,0,0,'0,0,3'b000, 0,1,1,0,0, 0,0,0,0,3'd1,0,Q));
    vecs.push_back(mk("clear1",        1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,Q));
    vecs.push_back(mk("go_d",          1,0,0,1,D, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("done_bus_hr",   1,0,0,0,'0,0,3'b000, 1,1,0,1,1, 0,0,0,0,3'd5,0,D));
    vecs.push_back(mk("clear5",        1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,D));
    vecs.push_back(mk("err_and_clr",   1,0,0,1,B5,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd2,0,B5));
    vecs.push_back(mk("clear2",        1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,B5));
    vecs.push_back(mk("go_d2",         1,0,0,1,D, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("done_hr",       1,0,0,0,'0,0,3'b000, 1,1,0,0,1, 0,0,0,0,3'd4,0,D));
    vecs.push_back(mk("clear4",        1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,D));
    vecs.push_back(mk("go_d3",         1,0,0,1,D, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    vecs.push_back(mk("done_all",      1,0,0,0,'0,0,3'b000, 1,1,1,1,1, 0,0,0,0,3'd3,0,D));
    vecs.push_back(mk("clear3",        1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,D));
    vecs.push_back(mk("resume_hreq",   1,1,1,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,1,3'd0,0,D));
    vecs.push_back(mk("resume_go",     1,0,1,0,'0,0,3'b000, 1,0,0,0,0, 0,1,0,0,3'd0,0,D));
    vecs.push_back(mk("resume_w1",     1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,1,0,0,3'd0,0,D));
    vecs.push_back(mk("resume_done",   1,0,0,0,'0,0,3'b000, 0,0,0,0,0, 0,0,0,0,3'd0,1,D));
    vecs.push_back(mk("resume_run",    1,0,1,0,'0,0,3'b000, 0,0,0,0,0, 0,0,0,0,3'd0,1,D));
    vecs.push_back(mk("resume_go2",    1,0,1,0,'0,0,3'b000, 1,0,0,0,0, 0,1,0,0,3'd0,0,D));
    vecs.push_back(mk("cmd_in_resume", 1,0,0,1,Q, 0,3'b000, 1,0,0,0,0, 0,1,0,0,3'd1,0,D));
    vecs.push_back(mk("resume_done2",  1,0,0,0,'0,0,3'b000, 0,0,0,0,0, 0,0,0,0,3'd1,1,D));
    vecs.push_back(mk("dm_off",        0,1,0,1,D, 0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    vecs.push_back(mk("dm_off_resume", 0,0,1,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    vecs.push_back(mk("dm_on",         1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    vecs.push_back(mk("haltreq_on",    1,1,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,1,3'd0,0,'0));

    drive(mk("init", 1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    rst_n = 1'b0;
    #12;
    check("reset_state", outs(), 40'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // EXEC with no hart_done
    step(mk("to_go", 1,0,0,1,D, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,D));
    @(negedge clk);
    drive(mk("hold", 1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    n = 1;
`ifdef DM_ABSTRACT_TIMEOUT_EN
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (!dm.exec) break;
      n++;
    end
    check_int("timeout_exec_cycles", n, 255);
    check("timeout_state", outs(), {1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,D});
    step(mk("timeout_clr", 1,0,0,0,'0,1,3'b111, 1,0,0,0,0, 0,0,0,0,3'd0,0,D));
`else
    for (int c = 0; c < 299; c++) begin
      @(posedge clk);
      #1;
      if (dm.exec) n++;
    end
    check_int("no_timeout_exec_cycles", n, 300);
    step(mk("late_done", 1,0,0,0,'0,0,3'b000, 1,1,0,0,0, 0,0,0,0,3'd0,0,D));
`endif

    // Asynchronous reset in the middle of EXEC
    step(mk("rst_go", 1,0,0,1,R, 0,3'b000, 1,0,0,0,0, 1,0,1,0,3'd0,0,R));
    @(negedge clk);
    drive(mk("rst_hold", 1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_exec", outs(), 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("after_reset", 1,0,0,0,'0,0,3'b000, 1,0,0,0,0, 0,0,0,0,3'd0,0,'0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
